// File: rtl/turn_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : turn_timer_ctrl
// Purpose  : Per-turn second counter for the game. Divides clk down to a
//            1 s tick, runs an IDLE/RUN/PAUSE/EXPIRED sequencer driven by the
//            game FSM, counts elapsed seconds up to LIMIT_S, pulses timeout
//            for one cycle on expiry and presents two BCD digits to the
//            7-segment display path.
// Ports    : clk        - system clock, rising edge
//            rst        - asynchronous active-high reset
//            start      - begin a turn (from IDLE or EXPIRED)
//            move_done  - player moved; restart the turn at 0 s
//            pause      - hold the count while high
//            abort      - return to IDLE
//            running    - high in RUN
//            paused     - high in PAUSE
//            expired    - high in EXPIRED
//            timeout    - one-cycle pulse on entry to EXPIRED
//            seconds    - elapsed seconds, 0..LIMIT_S
//            bcd_tens   - tens digit of the displayed value
//            bcd_ones   - ones digit of the displayed value
// Options  : define COUNTDOWN_EN to display remaining time (LIMIT_S-seconds)
//            instead of elapsed time. The seconds port is unaffected.
// Revision : 1.0 - initial release
// ============================================================================
module turn_timer_ctrl #(
   parameter int CLK_HZ  = 50000000,
   parameter int LIMIT_S = 15,
   parameter int SEC_W   = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             move_done,
   input  logic             pause,
   input  logic             abort,
   output logic             running,
   output logic             paused,
   output logic             expired,
   output logic             timeout,
   output logic [SEC_W-1:0] seconds,
   output logic [3:0]       bcd_tens,
   output logic [3:0]       bcd_ones
);

   localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_HZ - 1);
   localparam logic [SEC_W-1:0] SEC_LIMIT = SEC_W'(LIMIT_S);
   localparam logic [SEC_W-1:0] SEC_LAST  = SEC_W'(LIMIT_S - 1);
   localparam logic [SEC_W-1:0] TEN       = SEC_W'(10);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RUN     = 2'd1;
   localparam logic [1:0] PAUSE   = 2'd2;
   localparam logic [1:0] EXPIRED = 2'd3;

   logic [1:0]       state;
   logic [1:0]       state_nx;
   logic [PRE_W-1:0] prescaler;
   logic [PRE_W-1:0] prescaler_nx;
   logic [SEC_W-1:0] sec;
   logic [SEC_W-1:0] sec_nx;
   logic             timeout_q;
   logic             timeout_nx;
   logic [SEC_W-1:0] disp;

   // Next-state logic. Priority: abort > move_done > start > pause.
   // The prescaler only advances on cycles that stay in RUN without pause, so
   // entering PAUSE freezes it mid-second and resuming picks up where it was.
   always_comb begin
      state_nx     = state;
      prescaler_nx = prescaler;
      sec_nx       = sec;
      timeout_nx   = 1'b0;

      if (abort) begin
         state_nx     = IDLE;
         prescaler_nx = '0;
         sec_nx       = '0;
      end else begin
         case (state)
            IDLE: begin
               prescaler_nx = '0;
               sec_nx       = '0;
               if (start) begin
                  state_nx = RUN;
               end
            end
            RUN: begin
               if (move_done) begin
                  // Restart discards any tick due this cycle.
                  prescaler_nx = '0;
                  sec_nx       = '0;
               end else if (pause) begin
                  state_nx = PAUSE;
               end else if (prescaler == PRE_LAST) begin
                  prescaler_nx = '0;
                  if (sec == SEC_LAST) begin
                     sec_nx     = SEC_LIMIT;
                     state_nx   = EXPIRED;
                     timeout_nx = 1'b1;
                  end else begin
                     sec_nx = sec + 1'b1;
                  end
               end else begin
                  prescaler_nx = prescaler + 1'b1;
               end
            end
            PAUSE: begin
               if (move_done) begin
                  state_nx     = RUN;
                  prescaler_nx = '0;
                  sec_nx       = '0;
               end else if (!pause) begin
                  state_nx = RUN;
               end
            end
            EXPIRED: begin
               if (start) begin
                  state_nx     = RUN;
                  prescaler_nx = '0;
                  sec_nx       = '0;
               end
            end
            default: begin
               state_nx     = IDLE;
               prescaler_nx = '0;
               sec_nx       = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         prescaler <= '0;
         sec       <= '0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_nx;
         prescaler <= prescaler_nx;
         sec       <= sec_nx;
         timeout_q <= timeout_nx;
      end
   end

   assign running = (state == RUN);
   assign paused  = (state == PAUSE);
   assign expired = (state == EXPIRED);
   assign timeout = timeout_q;
   assign seconds = sec;

   // Display value decoded straight from the seconds register, so the digits
   // change in the same cycle as seconds.
`ifdef COUNTDOWN_EN
   assign disp = SEC_LIMIT - sec;
`else
   assign disp = sec;
`endif

   assign bcd_tens = 4'(disp / TEN);
   assign bcd_ones = 4'(disp % TEN);

endmodule
`default_nettype wire

// File: tb/tb_turn_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_turn_timer_ctrl
// Purpose  : Self-checking bench for turn_timer_ctrl (CLK_HZ=4, LIMIT_S=15).
//            A reference model tracks the total number of counted RUN cycles
//            in the current turn and derives seconds/state from it; every
//            falling edge the DUT outputs are compared against it. Directed
//            scenarios add literal expectations at key points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_turn_timer_ctrl;

   localparam int CLK_HZ  = 4;
   localparam int LIMIT_S = 15;
   localparam int SEC_W   = 7;

`ifdef COUNTDOWN_EN
   localparam int RST_T  = 1;   // display of 0 s elapsed -> 15 remaining
   localparam int RST_O  = 5;
   localparam int LIM_T  = 0;   // display at expiry -> 0 remaining
   localparam int LIM_O  = 0;
`else
   localparam int RST_T  = 0;
   localparam int RST_O  = 0;
   localparam int LIM_T  = 1;
   localparam int LIM_O  = 5;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             move_done = 1'b0;
   logic             pause = 1'b0;
   logic             abort = 1'b0;
   logic             running;
   logic             paused;
   logic             expired;
   logic             timeout;
   logic [SEC_W-1:0] seconds;
   logic [3:0]       bcd_tens;
   logic [3:0]       bcd_ones;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   turn_timer_ctrl #(
      .CLK_HZ (CLK_HZ),
      .LIMIT_S(LIMIT_S),
      .SEC_W  (SEC_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .move_done(move_done),
      .pause    (pause),
      .abort    (abort),
      .running  (running),
      .paused   (paused),
      .expired  (expired),
      .timeout  (timeout),
      .seconds  (seconds),
      .bcd_tens (bcd_tens),
      .bcd_ones (bcd_ones)
   );

   // ---------------------------------------------------------------------
   // Reference model: one accumulator of counted RUN cycles per turn.
   // seconds = acc / CLK_HZ; the turn expires when acc reaches LIMIT_S*CLK_HZ.
   // ---------------------------------------------------------------------
   typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_EXP} mode_t;
   mode_t m_mode = M_IDLE;
   int    m_acc  = 0;
   bit    m_to   = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode <= M_IDLE;
         m_acc  <= 0;
         m_to   <= 1'b0;
      end else begin
         m_to <= 1'b0;
         if (abort) begin
            m_mode <= M_IDLE;
            m_acc  <= 0;
         end else if (move_done && (m_mode == M_RUN || m_mode == M_PAUSE)) begin
            m_mode <= M_RUN;
            m_acc  <= 0;
         end else if (start && (m_mode == M_IDLE || m_mode == M_EXP)) begin
            m_mode <= M_RUN;
            m_acc  <= 0;
         end else if (m_mode == M_RUN && pause) begin
            m_mode <= M_PAUSE;
         end else if (m_mode == M_PAUSE && !pause) begin
            m_mode <= M_RUN;
         end else if (m_mode == M_RUN) begin
            m_acc <= m_acc + 1;
            if (m_acc + 1 == LIMIT_S * CLK_HZ) begin
               m_mode <= M_EXP;
               m_to   <= 1'b1;
            end
         end
      end
   end

   task automatic check(input string name, input int actual, input int expected);
      n_cmp++;
      if (actual != expected) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
      end
   endtask

   // Continuous comparison against the model on every falling edge.
   always @(negedge clk) begin
      int m_sec;
      int m_disp;
      m_sec = m_acc / CLK_HZ;
`ifdef COUNTDOWN_EN
      m_disp = LIMIT_S - m_sec;
`else
      m_disp = m_sec;
`endif
      check("model.running", int'(running), int'(m_mode == M_RUN));
      check("model.paused",  int'(paused),  int'(m_mode == M_PAUSE));
      check("model.expired", int'(expired), int'(m_mode == M_EXP));
      check("model.timeout", int'(timeout), int'(m_to));
      check("model.seconds", int'(seconds), m_sec);
      check("model.tens",    int'(bcd_tens), m_disp / 10);
      check("model.ones",    int'(bcd_ones), m_disp % 10);
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      // Reset state
      step(2);
      check("rst.seconds", int'(seconds), 0);
      check("rst.running", int'(running), 0);
      check("rst.timeout", int'(timeout), 0);
      check("rst.tens", int'(bcd_tens), RST_T);
      check("rst.ones", int'(bcd_ones), RST_O);
      rst = 1'b0;
      step(2);
      check("idle.running", int'(running), 0);

      // Full turn to expiry
      start = 1'b1;
      step(1);
      start = 1'b0;
      check("t1.running", int'(running), 1);
      check("t1.sec0", int'(seconds), 0);
      step(59);
      check("t1.sec14", int'(seconds), 14);
      check("t1.no_to_yet", int'(timeout), 0);
      step(1);
      check("t1.sec15", int'(seconds), 15);
      check("t1.timeout", int'(timeout), 1);
      check("t1.tens", int'(bcd_tens), LIM_T);
      check("t1.ones", int'(bcd_ones), LIM_O);
      step(1);
      check("t1.to_one_cycle", int'(timeout), 0);
      check("t1.expired", int'(expired), 1);
      pause = 1'b1;               // ignored in EXPIRED
      step(3);
      pause = 1'b0;
      check("exp.pause_ign", int'(expired), 1);

      // Restart from EXPIRED, then abort at 9 s
      start = 1'b1;
      step(1);
      start = 1'b0;
      check("t4.running", int'(running), 1);
      check("t4.sec0", int'(seconds), 0);
      step(36);
      check("t4.sec9", int'(seconds), 9);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      check("t4.idle", int'(running), 0);
      check("t4.sec_clr", int'(seconds), 0);
      check("t4.no_to", int'(timeout), 0);

      // Pause at seconds=7, prescaler=2
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(30);
      check("t2.sec7", int'(seconds), 7);
      pause = 1'b1;
      step(10);
      check("t2.paused", int'(paused), 1);
      check("t2.frozen", int'(seconds), 7);
      pause = 1'b0;
      step(1);
      check("t2.resumed", int'(running), 1);
      step(1);
      check("t2.not_yet", int'(seconds), 7);
      step(1);
      check("t2.tick", int'(seconds), 8);

      // move_done on the final tick
      step(27);
      check("t3.sec14", int'(seconds), 14);
      move_done = 1'b1;
      step(1);
      move_done = 1'b0;
      check("t3.sec0", int'(seconds), 0);
      check("t3.running", int'(running), 1);
      check("t3.no_to", int'(timeout), 0);
      step(2);
      check("t3.still_no_to", int'(expired), 0);

      // Asynchronous reset mid-cycle at 12 s
      step(46);
      check("t5.sec12", int'(seconds), 12);
      #2;
      rst = 1'b1;
      #1;
      check("t5.async_sec", int'(seconds), 0);
      check("t5.async_run", int'(running), 0);
      check("t5.async_tens", int'(bcd_tens), RST_T);
      check("t5.async_ones", int'(bcd_ones), RST_O);
      step(2);
      rst = 1'b0;
      step(5);
      check("t5.stay_idle", int'(running), 0);

      // start+pause+move_done in IDLE; start held in RUN
      start = 1'b1;
      pause = 1'b1;
      move_done = 1'b1;
      step(1);
      check("t6.running", int'(running), 1);
      check("t6.not_paused", int'(paused), 0);
      pause = 1'b0;
      move_done = 1'b0;
      step(8);
      check("t6.start_ign", int'(seconds), 2);
      // abort wins over everything
      abort = 1'b1;
      move_done = 1'b1;
      step(1);
      abort = 1'b0;
      move_done = 1'b0;
      start = 1'b0;
      check("t6.abort_wins", int'(running), 0);
      step(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/turn_timer_ctrl.md
Name: turn_timer_ctrl

Overview:
Sequencer for the game's per-turn second counter and its two 7-segment digits. It divides the system clock to a 1 s tick and runs a start/pause/restart/abort state machine. It counts elapsed seconds up to LIMIT_S, raises a one-cycle timeout, and presents BCD tens/ones to the display controller. It sits between the game FSM (start, move_done, pause, abort) and the BCD display path.

Parameters:
CLK_HZ, 50000000, system clock frequency; prescaler terminal count is CLK_HZ-1
LIMIT_S, 15, turn length in seconds; legal range 1..99
SEC_W, 7, width of the seconds register; must hold 99

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  level; begin a turn from IDLE or EXPIRED
move_done  input  1  level; player moved, restart turn at 0 s
pause  input  1  level; hold the count while high
abort  input  1  level; return to IDLE
running  output  1  high in RUN
paused  output  1  high in PAUSE
expired  output  1  high in EXPIRED
timeout  output  1  one-cycle pulse on entry to EXPIRED
seconds  output  SEC_W  elapsed seconds, 0..LIMIT_S
bcd_tens  output  4  tens digit of the displayed value
bcd_ones  output  4  ones digit of the displayed value

Behaviour:
- Reset (async, rst=1): state=IDLE, prescaler=0, seconds=0, all 1-bit outputs=0, bcd_tens=0, bcd_ones=0 (bcd_ones=LIMIT_S%10 and bcd_tens=LIMIT_S/10 with COUNTDOWN_EN).
- States: IDLE, RUN, PAUSE, EXPIRED. Input priority per cycle: abort > move_done > start > pause.
- IDLE: prescaler and seconds are held at 0. start=1 moves to RUN next edge.
- RUN: prescaler increments each cycle. At CLK_HZ-1 it wraps to 0 and tick=1. On tick, seconds increments.
- When tick occurs with seconds==LIMIT_S-1: seconds becomes LIMIT_S, state goes to EXPIRED, and timeout=1 for exactly that next cycle.
- RUN with pause=1 moves to PAUSE. The prescaler and seconds are frozen and no tick is lost or added. PAUSE with pause=0 returns to RUN, and the prescaler resumes from its frozen value.
- move_done=1 in RUN or PAUSE clears the prescaler and seconds to 0 and enters RUN. Any tick on that same cycle is discarded, so no timeout is raised. move_done in IDLE or EXPIRED is ignored.
- EXPIRED: seconds is held at LIMIT_S and expired=1. start=1 clears the counters and enters RUN. pause is ignored.
- abort=1 in any state clears the counters and enters IDLE next edge, with no timeout pulse.
- start is ignored in RUN and PAUSE.
- All outputs are registered or decoded from registers; there is no combinational path from inputs to outputs.
- Latency: a state or count change is visible on the outputs one cycle after the sampling edge.
- BCD outputs: the displayed value is split by divide/modulo 10. Both digits are 0..9 and always valid.
- Display update: the BCD outputs update in the same cycle as seconds.

Optional Feature:
COUNTDOWN_EN: when defined, the BCD outputs show LIMIT_S-seconds (remaining time), reading 15 -> 0. The seconds port is unchanged. When undefined, the BCD outputs show seconds (elapsed time), reading 0 -> 15.

Test Plan:
- CLK_HZ=4, LIMIT_S=15, start pulse -> running=1 next cycle. seconds increments every 4 cycles. After 60 clocks in RUN, seconds=15 and timeout is high for exactly 1 cycle, followed by expired=1. BCD reads 1,5 (0,0 with COUNTDOWN_EN).
- During RUN at seconds=7 with prescaler=2, hold pause for 10 cycles -> seconds stays 7 and paused=1. On release, the next increment arrives exactly 2 cycles later.
- Assert move_done on the same cycle as the final tick (seconds=14) -> seconds=0, state RUN, timeout never asserted.
- EXPIRED, then start -> seconds=0 and running=1. Assert abort at seconds=9 -> IDLE, seconds=0, no timeout.
- Assert rst asynchronously mid-cycle at seconds=12 in RUN -> all outputs take their reset values immediately, without waiting for a clock edge. After release, the block stays in IDLE until start.
- With start, pause and move_done all high in IDLE -> enters RUN. Assert start in RUN -> no effect on seconds.
